// File: rtl/serial_pkg.sv
// Shared types and frame timing helper for the serial transmit arbiter.
package serial_pkg;

  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FRAME
  } tx_arb_state_t;

  function automatic int frame_cycles(int divisor, int guard);
    return FRAME_BITS * (divisor + 1) + guard;
  endfunction

endpackage

// File: rtl/serial_tx_arbiter_if.sv
// Requester and transmitter-side signals of the serial transmit arbiter.
interface serial_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_valid_in;
  logic [8*NUM_REQ-1:0] req_data_in;
  logic [NUM_REQ-1:0]   req_ready_out;
  logic [7:0]           tx_val_out;
  logic                 tx_trigger_out;
  logic [2:0]           grant_id_out;
  logic                 busy_out;

  modport master (
    output req_valid_in,
    output req_data_in,
    input  req_ready_out,
    input  tx_val_out,
    input  tx_trigger_out,
    input  grant_id_out,
    input  busy_out
  );

  modport slave (
    input  req_valid_in,
    input  req_data_in,
    output req_ready_out,
    output tx_val_out,
    output tx_trigger_out,
    output grant_id_out,
    output busy_out
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker; remembers the last winner and scans from the one after it.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N-1:0]                 req_i,
  input  logic                         en_i,
  output logic [N-1:0]                 grant_onehot_o,
  output logic [((N>1)?$clog2(N):1)-1:0] grant_idx_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] pos;
  logic          found;

  always_comb begin
    found          = 1'b0;
    pos            = '0;
    grant_idx_o    = '0;
    grant_onehot_o = '0;
    for (int i = 1; i <= N; i++) begin
      pos = IW'((int'(last_q) + i) % N);
      if (!found && req_i[pos]) begin
        found       = 1'b1;
        grant_idx_o = pos;
      end
    end
    last_d = last_q;
    if (en_i && found) begin
      grant_onehot_o[grant_idx_o] = 1'b1;
      last_d                      = grant_idx_o;
    end
  end

  // Start at N-1 so requester 0 wins the first scan after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= IW'(N - 1);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one 8N1 transmitter between requesters; times each frame itself
// because the transmitter exposes no busy flag.
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIVISOR = 868,
  parameter int GUARD   = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  serial_tx_arbiter_if.slave  bus
);

  localparam int FC = frame_cycles(DIVISOR, GUARD);
  localparam int CW = $clog2(FC + 1);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  tx_arb_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    val_q, val_d;
  logic [2:0]    gid_q, gid_d;
  logic          busy_q, busy_d;

  logic               arb_en;
  logic               accept;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [IW-1:0]      gnt_idx;

  // Reset wins over a same-cycle valid, so no accept is offered then.
  assign arb_en = (state_q == IDLE) && !rst_in;
  assign accept = |gnt_oh;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk_i          (clk_in),
    .rst_i          (rst_in),
    .req_i          (bus.req_valid_in),
    .en_i           (arb_en),
    .grant_onehot_o (gnt_oh),
    .grant_idx_o    (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    gid_d   = gid_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          val_d   = bus.req_data_in[{gnt_idx, 3'b000} +: 8];
          gid_d   = 3'(gnt_idx);
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = FRAME;
      end
      FRAME: begin
        if (cnt_q == CW'(FC - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.req_ready_out  = gnt_oh;
  assign bus.tx_val_out     = val_q;
  assign bus.tx_trigger_out = (state_q == LOAD);
  assign bus.grant_id_out   = gid_q;
  assign bus.busy_out       = busy_q;

endmodule
